// File: rtl/sobel_window_3x3.sv
`default_nettype none
// ============================================================================
// Module   : sobel_window_3x3
// Brief    : Streaming 3x3 neighbourhood generator with border masking and
//            end-of-frame self-flush, feeding the Sobel convolver.
// Revision : 1.0 - initial release
// ============================================================================
module sobel_window_3x3 #(
  parameter int WIDTH  = 128,
  parameter int HEIGHT = 128,
  parameter int BITW   = 8,
  parameter int COLW   = 7,
  parameter int ROWW   = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [BITW-1:0]     in_pix,
  output logic                in_ready,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [9*BITW-1:0]   out_win,
  output logic [ROWW-1:0]     out_row,
  output logic [COLW-1:0]     out_col,
  output logic                out_border,
  output logic                out_last,
  output logic                busy
);

  localparam int FW = $clog2(WIDTH + 1);

  localparam logic [0:0]      c_st_run     = 1'b0;
  localparam logic [0:0]      c_st_flush   = 1'b1;
  localparam logic [COLW-1:0] c_col_last   = COLW'(WIDTH - 1);
  localparam logic [ROWW-1:0] c_row_last   = ROWW'(HEIGHT - 1);
  localparam logic [FW-1:0]   c_flush_last = FW'(WIDTH);

  logic [0:0]      r_state;
  logic [COLW-1:0] r_pcol, r_ccol;
  logic [ROWW-1:0] r_prow, r_crow;
  logic [FW-1:0]   r_fcnt;

  logic [BITW-1:0] r_lb0 [0:WIDTH-1];
  logic [BITW-1:0] r_lb1 [0:WIDTH-1];
  logic [BITW-1:0] r_ta  [0:2];
  logic [BITW-1:0] r_tb  [0:2];

  logic              r_out_valid, r_out_border, r_out_last;
  logic [9*BITW-1:0] r_out_win;
  logic [ROWW-1:0]   r_out_row;
  logic [COLW-1:0]   r_out_col;

  logic              w_run, w_adv, w_accept, w_push, w_primed, w_emit;
  logic              w_frame_end, w_flush_end, w_border, w_last;
  logic [BITW-1:0]   w_pix;
  logic [BITW-1:0]   w_new [0:2];
  logic [BITW-1:0]   w_raw [0:8];
  logic [9*BITW-1:0] w_win;

  assign w_run       = (r_state == c_st_run);
  assign w_adv       = !r_out_valid || out_ready;
  assign in_ready    = w_adv && w_run;
  assign w_accept    = in_valid && in_ready;
  assign w_push      = w_accept || (w_adv && !w_run);
  assign w_pix       = w_run ? in_pix : '0;
  // No window exists until the push index reaches WIDTH+1.
  assign w_primed    = !w_run || (r_prow > ROWW'(1)) ||
                       ((r_prow == ROWW'(1)) && (r_pcol != '0));
  assign w_emit      = w_push && w_primed;
  assign w_frame_end = w_accept && (r_prow == c_row_last) && (r_pcol == c_col_last);
  assign w_flush_end = w_push && !w_run && (r_fcnt == c_flush_last);
  assign w_border    = (r_crow == '0) || (r_crow == c_row_last) ||
                       (r_ccol == '0) || (r_ccol == c_col_last);
  assign w_last      = (r_crow == c_row_last) && (r_ccol == c_col_last);

  always_comb begin
    w_new[0] = r_lb1[r_pcol];
    w_new[1] = r_lb0[r_pcol];
    w_new[2] = w_pix;
    w_win    = '0;
    for (int r = 0; r < 3; r++) begin
      w_raw[r*3+0] = r_ta[r];
      w_raw[r*3+1] = r_tb[r];
      w_raw[r*3+2] = w_new[r];
    end
    // Masking by centre position also hides stale line data and column wrap.
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        if (!((r == 0) && (r_crow == '0)) && !((r == 2) && (r_crow == c_row_last)) &&
            !((c == 0) && (r_ccol == '0)) && !((c == 2) && (r_ccol == c_col_last)))
          w_win[(r*3+c)*BITW +: BITW] = w_raw[r*3+c];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_lb1[r_pcol] <= w_new[1];
      r_lb0[r_pcol] <= w_pix;
      for (int i = 0; i < 3; i++) begin
        r_ta[i] <= r_tb[i];
        r_tb[i] <= w_new[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_st_run;
      r_pcol  <= '0;
      r_prow  <= '0;
      r_fcnt  <= '0;
      r_ccol  <= '0;
      r_crow  <= '0;
    end else begin
      if (w_push) begin
        r_pcol <= (r_pcol == c_col_last) ? '0 : r_pcol + 1'b1;
        if (w_run && (r_pcol == c_col_last))
          r_prow <= (r_prow == c_row_last) ? '0 : r_prow + 1'b1;
        if (!w_run)
          r_fcnt <= r_fcnt + 1'b1;
      end
      if (w_emit) begin
        r_ccol <= (r_ccol == c_col_last) ? '0 : r_ccol + 1'b1;
        if (r_ccol == c_col_last)
          r_crow <= (r_crow == c_row_last) ? '0 : r_crow + 1'b1;
      end
      if (w_frame_end)
        r_state <= c_st_flush;
      if (w_flush_end) begin
        r_state <= c_st_run;
        r_pcol  <= '0;
        r_prow  <= '0;
        r_fcnt  <= '0;
        r_ccol  <= '0;
        r_crow  <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_win    <= '0;
      r_out_row    <= '0;
      r_out_col    <= '0;
      r_out_border <= 1'b0;
      r_out_last   <= 1'b0;
    end else if (w_emit) begin
      r_out_valid  <= 1'b1;
      r_out_win    <= w_win;
      r_out_row    <= r_crow;
      r_out_col    <= r_ccol;
      r_out_border <= w_border;
      r_out_last   <= w_last;
    end else if (w_adv) begin
      r_out_valid  <= 1'b0;
    end
  end

  assign out_valid  = r_out_valid;
  assign out_win    = r_out_win;
  assign out_row    = r_out_row;
  assign out_col    = r_out_col;
  assign out_border = r_out_border;
  assign out_last   = r_out_last;
  assign busy       = !w_run || (r_pcol != '0) || (r_prow != '0);

endmodule
`default_nettype wire

// File: doc/sobel_window_3x3.md
Name: sobel_window_3x3

Overview:
- Streaming 3x3 window generator that sits directly upstream of the Sobel convolution stage.
- Accepts one raster-order pixel per handshake and stores two image lines plus a 3x3 tap array.
- Emits one 3x3 neighbourhood per image pixel (WIDTH*HEIGHT windows per frame), tagged with centre coordinates and a border flag; the convolver forces border outputs to 0.
- Self-flushes at end of frame so the last row's windows are emitted without extra input.

Parameters:
WIDTH, 128, image width in pixels (>=3)
HEIGHT, 128, image height in lines (>=3)
BITW, 8, pixel width in bits
COLW, 7, column counter width, >= clog2(WIDTH)
ROWW, 7, row counter width, >= clog2(HEIGHT)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  upstream pixel valid
in_pix  in  BITW  pixel, raster order, unsigned
in_ready  out  1  block accepts in_pix this cycle
out_valid  out  1  window valid
out_ready  in  1  downstream accepts window
out_win  out  9*BITW  taps w00..w22 row-major; w00 in [BITW-1:0], w22 in [9*BITW-1:8*BITW]; wRC is pixel (row-1+R, col-1+C)
out_row  out  ROWW  centre row
out_col  out  COLW  centre column
out_border  out  1  centre on row 0, row HEIGHT-1, col 0 or col WIDTH-1
out_last  out  1  window for centre (HEIGHT-1, WIDTH-1)
busy  out  1  state is FLUSH, or a frame is partially received

Behaviour:
- Clock is clk. rst is synchronous and active-high.
- On rst: out_valid=0, out_win=0, out_row=0, out_col=0, out_border=0, out_last=0, busy=0, state=RUN, all counters=0. Line-buffer contents are don't-care.
- Stage advance: adv = !out_valid || out_ready.
- in_ready = adv && (state==RUN). Combinational from out_ready is allowed.
- Push: an accepted pixel in RUN, or one internal zero pixel per adv cycle in FLUSH. Each push has raster index i, counted 0..N+WIDTH where N = WIDTH*HEIGHT.
- Push with i >= WIDTH+1: on the next edge, load the output registers with the window centred at index i-(WIDTH+1) and set out_valid=1.
- Push with i < WIDTH+1: no window is produced. If adv holds, out_valid clears.
- Cycle with adv=1 and no push: out_valid clears.
- Cycle with adv=0: output registers hold stable, including out_win and the tags.
- Latency: a window is valid one cycle after the push of pixel (row+1, col+1) in raster terms.
- Out-of-image taps read as 0, i.e. any tap whose row is outside 0..HEIGHT-1 or whose column is outside 0..WIDTH-1.
- Column wrap must be masked. Example: w00 for col 0 must not alias the previous line's last pixel.
- State RUN -> FLUSH: on acceptance of the pixel with index N-1.
- State FLUSH: in_ready=0 and in_valid is ignored. Perform WIDTH+1 zero pushes, one per adv cycle. The final push emits the window with out_last=1.
- State FLUSH -> RUN: after the final push, with all counters cleared. The next accepted pixel is (0,0) of a new frame.
- Back-to-back frames need no gap beyond the flush.
- rst mid-frame or mid-flush: the partial frame is discarded, no further windows are emitted, and the next accepted pixel is (0,0).
- Counters wrap exactly at WIDTH-1 / HEIGHT-1. There is no overflow into unused counter codes.
- Arithmetic: none on pixel data. Taps are pass-through copies of in_pix or 0.
- Throughput: 1 window/cycle in steady state with out_ready=1.

Test Plan:
- WIDTH=4, HEIGHT=4, pixels = index 0..15, out_ready=1, continuous valid -> first out_valid the cycle after pixel 5 accepted. Centre (0,0): w11=0, w12=1, w21=4, w22=5, other taps 0, border=1.
- Same stream, centre (1,1) -> w00..w22 = 0,1,2,4,5,6,8,9,10; border=0. Centre (1,2) -> 1,2,3,5,6,7,9,10,11.
- Same stream, centre (1,3) -> w02=w12=w22=0 (no wrap to next row); w00=2, w11=7; border=1.
- End of frame -> in_ready=0 for exactly 5 push cycles. 16 windows total. Last window is centre (3,3) with w00=10, w11=15, bottom row 0, out_last=1. Then in_ready=1.
- out_ready random 50% -> windows unchanged while stalled, none lost or duplicated, order and contents identical to the out_ready=1 run. Check against the 128x128 Lena hex through the downstream Sobel stage for a matching PGM.
- rst asserted after 7 pixels, then a fresh frame -> out_valid=0 the cycle after rst. First new window is centre (0,0) of the new data.
